// File: rtl/ex_mem_stage.sv
// Execute stage with rs/rt forwarding, ALU, destination select and the EX/MEM register (falling-edge clocked).
// Define MULT_EN to add the iterative shift-add multiplier (funct 011000) that stalls the front of the pipe.
module ex_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int MUL_STEPS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Rs_data_in,
  input  logic [DATA_W-1:0] Rt_data_in,
  input  logic [DATA_W-1:0] Imm_in,
  input  logic [ADDR_W-1:0] Rs_addr_in,
  input  logic [ADDR_W-1:0] Rt_addr_in,
  input  logic [ADDR_W-1:0] Rd_addr_in,
  input  logic [1:0]        ALU_op_in,
  input  logic              ALU_src_in,
  input  logic              Reg_dst_in,
  input  logic              Reg_w_in,
  input  logic              Mem_w_in,
  input  logic              Mem_r_in,
  input  logic              Mem_to_reg_in,
  input  logic              Wb_reg_w,
  input  logic [ADDR_W-1:0] Wb_addr,
  input  logic [DATA_W-1:0] Wb_data,
  output logic [DATA_W-1:0] Alu_result_out,
  output logic [DATA_W-1:0] Rt_data_out,
  output logic [ADDR_W-1:0] Wr_addr_out,
  output logic              Zero_out,
  output logic              Reg_w_out,
  output logic              Mem_w_out,
  output logic              Mem_r_out,
  output logic              Mem_to_reg_out,
  output logic              Stall_out
);

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  if (MUL_STEPS != DATA_W) begin : g_bad_steps
    $error("MUL_STEPS must equal DATA_W");
  end

  function automatic logic [DATA_W-1:0] alu_eval(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic [1:0]               op,
    input logic [5:0]               fn
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (op)
      2'b01: r = a - b;
      2'b10: begin
        case (fn)
          FN_ADD:  r = a + b;
          FN_SUB:  r = a - b;
          FN_AND:  r = a & b;
          FN_OR:   r = a | b;
          FN_SLT:  r = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
          default: r = '0;
        endcase
      end
      default: r = a + b;
    endcase
    return r;
  endfunction

  // ---- stage p0: forwarding, operand select, ALU ----
  logic signed [DATA_W-1:0] fwd_a_p0, fwd_b_p0, op_b_p0;
  logic [DATA_W-1:0]        alu_res_p0, ex_res_p0;
  logic [ADDR_W-1:0]        dest_p0;
  logic                     stall_p0;

  always_comb begin
    fwd_a_p0 = Rs_data_in;
    if (Reg_w_out && Wr_addr_out != '0 && Wr_addr_out == Rs_addr_in)
      fwd_a_p0 = Alu_result_out;
    else if (Wb_reg_w && Wb_addr != '0 && Wb_addr == Rs_addr_in)
      fwd_a_p0 = Wb_data;
  end

  always_comb begin
    fwd_b_p0 = Rt_data_in;
    if (Reg_w_out && Wr_addr_out != '0 && Wr_addr_out == Rt_addr_in)
      fwd_b_p0 = Alu_result_out;
    else if (Wb_reg_w && Wb_addr != '0 && Wb_addr == Rt_addr_in)
      fwd_b_p0 = Wb_data;
  end

  assign op_b_p0    = ALU_src_in ? Imm_in : fwd_b_p0;
  assign alu_res_p0 = alu_eval(fwd_a_p0, op_b_p0, ALU_op_in, Imm_in[5:0]);
  assign dest_p0    = Reg_dst_in ? Rd_addr_in : Rt_addr_in;

`ifdef MULT_EN
  localparam int CNT_W = $clog2(MUL_STEPS + 1);
  localparam logic [5:0] FN_MULT = 6'b011000;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [DATA_W-1:0]        acc_p1, mcand_p1, mplier_p1;
  logic                     is_mult_p0, mul_done_p0;

  assign is_mult_p0 = (ALU_op_in == 2'b10) && (Imm_in[5:0] == FN_MULT);

  always_ff @(negedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_mult_p0) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_W'(MUL_STEPS - 1)) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_p0    = (state_q == BUSY) || (state_q == IDLE && is_mult_p0);
    mul_done_p0 = (state_q == DONE);
  end

  always_ff @(negedge clk) begin
    if (rst) cnt_q <= '0;
    else if (state_q == IDLE) cnt_q <= '0;
    else if (state_q == BUSY) cnt_q <= cnt_q + 1'b1;
  end

  // ---- stage p1: shift-add product, operands frozen when the multiply starts ----
  always_ff @(negedge clk) begin
    if (state_q == IDLE && is_mult_p0) begin
      acc_p1    <= '0;
      mcand_p1  <= fwd_a_p0;
      mplier_p1 <= fwd_b_p0;
    end else if (state_q == BUSY) begin
      if (mplier_p1[0]) acc_p1 <= acc_p1 + mcand_p1;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

  assign ex_res_p0 = mul_done_p0 ? acc_p1 : alu_res_p0;
`else
  assign stall_p0  = 1'b0;
  assign ex_res_p0 = alu_res_p0;
`endif

  assign Stall_out = stall_p0;

  // ---- EX/MEM register: a stalled cycle loads a bubble ----
  always_ff @(negedge clk) begin
    if (rst || stall_p0) begin
      Alu_result_out <= '0;
      Rt_data_out    <= '0;
      Wr_addr_out    <= '0;
      Zero_out       <= 1'b0;
      Reg_w_out      <= 1'b0;
      Mem_w_out      <= 1'b0;
      Mem_r_out      <= 1'b0;
      Mem_to_reg_out <= 1'b0;
    end else begin
      Alu_result_out <= ex_res_p0;
      Rt_data_out    <= fwd_b_p0;
      Wr_addr_out    <= dest_p0;
      Zero_out       <= (ex_res_p0 == '0);
      Reg_w_out      <= Reg_w_in;
      Mem_w_out      <= Mem_w_in;
      Mem_r_out      <= Mem_r_in;
      Mem_to_reg_out <= Mem_to_reg_in;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: inputs change and outputs are sampled 1ns after each falling edge.
module tb_ex_mem_stage;
  logic        clk, rst;
  logic [31:0] Rs_data_in, Rt_data_in, Imm_in, Wb_data;
  logic [4:0]  Rs_addr_in, Rt_addr_in, Rd_addr_in, Wb_addr;
  logic [1:0]  ALU_op_in;
  logic        ALU_src_in, Reg_dst_in, Reg_w_in, Mem_w_in, Mem_r_in, Mem_to_reg_in, Wb_reg_w;
  logic [31:0] Alu_result_out, Rt_data_out;
  logic [4:0]  Wr_addr_out;
  logic        Zero_out, Reg_w_out, Mem_w_out, Mem_r_out, Mem_to_reg_out, Stall_out;
  int checks = 0;
  int failures = 0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst),
    .Rs_data_in(Rs_data_in), .Rt_data_in(Rt_data_in), .Imm_in(Imm_in),
    .Rs_addr_in(Rs_addr_in), .Rt_addr_in(Rt_addr_in), .Rd_addr_in(Rd_addr_in),
    .ALU_op_in(ALU_op_in), .ALU_src_in(ALU_src_in), .Reg_dst_in(Reg_dst_in),
    .Reg_w_in(Reg_w_in), .Mem_w_in(Mem_w_in), .Mem_r_in(Mem_r_in), .Mem_to_reg_in(Mem_to_reg_in),
    .Wb_reg_w(Wb_reg_w), .Wb_addr(Wb_addr), .Wb_data(Wb_data),
    .Alu_result_out(Alu_result_out), .Rt_data_out(Rt_data_out), .Wr_addr_out(Wr_addr_out),
    .Zero_out(Zero_out), .Reg_w_out(Reg_w_out), .Mem_w_out(Mem_w_out), .Mem_r_out(Mem_r_out),
    .Mem_to_reg_out(Mem_to_reg_out), .Stall_out(Stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [4:0] rs_a, input logic [31:0] rs_d,
                       input logic [4:0] rt_a, input logic [31:0] rt_d, input logic [4:0] rd_a,
                       input logic [31:0] imm, input logic src, input logic dst,
                       input logic rw, input logic mw, input logic mr, input logic m2r);
    ALU_op_in = op; Rs_addr_in = rs_a; Rs_data_in = rs_d; Rt_addr_in = rt_a; Rt_data_in = rt_d;
    Rd_addr_in = rd_a; Imm_in = imm; ALU_src_in = src; Reg_dst_in = dst;
    Reg_w_in = rw; Mem_w_in = mw; Mem_r_in = mr; Mem_to_reg_in = m2r;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    Wb_reg_w = en; Wb_addr = a; Wb_data = d;
  endtask

  task automatic test_reset();
    drive(2'b10, 5'd1, 32'h11, 5'd2, 32'h22, 5'd3, 32'h20, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    wb(1'b1, 5'd1, 32'h55);
    rst = 1'b1;
    tick();
    checks++; if (Alu_result_out !== 32'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", Alu_result_out); end
    checks++; if (Rt_data_out !== 32'h0) begin failures++; $display("FAIL reset_rt got=%h exp=0", Rt_data_out); end
    checks++; if (Wr_addr_out !== 5'd0) begin failures++; $display("FAIL reset_wr got=%0d exp=0", Wr_addr_out); end
    checks++; if ({Zero_out, Reg_w_out, Mem_w_out, Mem_r_out, Mem_to_reg_out} !== 5'b0)
      begin failures++; $display("FAIL reset_ctrl got=%b exp=00000", {Zero_out, Reg_w_out, Mem_w_out, Mem_r_out, Mem_to_reg_out}); end
    checks++; if (Stall_out !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall_out); end
    rst = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_sub();
    drive(2'b10, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'hFFFFFFFE) begin failures++; $display("FAIL sub_result got=%h exp=fffffffe", Alu_result_out); end
    checks++; if (Wr_addr_out !== 5'd3) begin failures++; $display("FAIL sub_wr got=%0d exp=3", Wr_addr_out); end
    checks++; if (Zero_out !== 1'b0) begin failures++; $display("FAIL sub_zero got=%b exp=0", Zero_out); end
    checks++; if (Rt_data_out !== 32'd7 || Reg_w_out !== 1'b1)
      begin failures++; $display("FAIL sub_pass got rt=%h rw=%b exp rt=7 rw=1", Rt_data_out, Reg_w_out); end
  endtask

  task automatic test_forward();
    drive(2'b10, 5'd1, 32'd10, 5'd2, 32'd20, 5'd3, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd30) begin failures++; $display("FAIL fwd_add got=%0d exp=30", Alu_result_out); end
    wb(1'b1, 5'd3, 32'd99);
    drive(2'b10, 5'd3, 32'd555, 5'd4, 32'd5, 5'd6, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd25) begin failures++; $display("FAIL fwd_a_prio got=%0d exp=25", Alu_result_out); end
    wb(1'b1, 5'd8, 32'd100);
    drive(2'b10, 5'd7, 32'd1, 5'd8, 32'd0, 5'd9, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd101 || Rt_data_out !== 32'd100)
      begin failures++; $display("FAIL fwd_b_wb got res=%0d rt=%0d exp res=101 rt=100", Alu_result_out, Rt_data_out); end
    wb(1'b1, 5'd9, 32'd5);
    drive(2'b10, 5'd10, 32'd2, 5'd9, 32'd0, 5'd11, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd103) begin failures++; $display("FAIL fwd_b_prio got=%0d exp=103", Alu_result_out); end
    wb(1'b0, 5'd0, 32'd0);
    drive(2'b10, 5'd1, 32'd4, 5'd2, 32'd4, 5'd0, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd8 || Wr_addr_out !== 5'd0)
      begin failures++; $display("FAIL r0_write got res=%0d wr=%0d exp res=8 wr=0", Alu_result_out, Wr_addr_out); end
    wb(1'b1, 5'd0, 32'd77);
    drive(2'b10, 5'd0, 32'd0, 5'd0, 32'd0, 5'd11, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd0 || Zero_out !== 1'b1)
      begin failures++; $display("FAIL r0_no_fwd got res=%0d zero=%b exp res=0 zero=1", Alu_result_out, Zero_out); end
    wb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_mem();
    drive(2'b00, 5'd8, 32'h100, 5'd12, 32'h0, 5'd13, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    checks++; if (Alu_result_out !== 32'hFC) begin failures++; $display("FAIL lw_addr got=%h exp=fc", Alu_result_out); end
    checks++; if (Wr_addr_out !== 5'd12 || Mem_r_out !== 1'b1 || Mem_to_reg_out !== 1'b1)
      begin failures++; $display("FAIL lw_ctrl got wr=%0d mr=%b m2r=%b exp wr=12 mr=1 m2r=1", Wr_addr_out, Mem_r_out, Mem_to_reg_out); end
    drive(2'b00, 5'd8, 32'h200, 5'd14, 32'hDEADBEEF, 5'd0, 32'h4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'h204 || Rt_data_out !== 32'hDEADBEEF)
      begin failures++; $display("FAIL sw_data got addr=%h rt=%h exp addr=204 rt=deadbeef", Alu_result_out, Rt_data_out); end
    checks++; if (Mem_w_out !== 1'b1 || Reg_w_out !== 1'b0 || Mem_r_out !== 1'b0)
      begin failures++; $display("FAIL sw_ctrl got mw=%b rw=%b mr=%b exp mw=1 rw=0 mr=0", Mem_w_out, Reg_w_out, Mem_r_out); end
    drive(2'b01, 5'd15, 32'd50, 5'd16, 32'd50, 5'd0, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd0 || Zero_out !== 1'b1)
      begin failures++; $display("FAIL beq_sub got res=%h zero=%b exp res=0 zero=1", Alu_result_out, Zero_out); end
  endtask

  task automatic test_logic();
    drive(2'b10, 5'd17, 32'hFFFFFFFF, 5'd18, 32'd1, 5'd19, 32'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd1) begin failures++; $display("FAIL slt_neg got=%h exp=1", Alu_result_out); end
    drive(2'b10, 5'd20, 32'd1, 5'd21, 32'hFFFFFFFF, 5'd22, 32'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd0 || Zero_out !== 1'b1)
      begin failures++; $display("FAIL slt_pos got res=%h zero=%b exp res=0 zero=1", Alu_result_out, Zero_out); end
    drive(2'b10, 5'd23, 32'hF0F0, 5'd24, 32'h0FF0, 5'd25, 32'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'h00F0) begin failures++; $display("FAIL and got=%h exp=f0", Alu_result_out); end
    drive(2'b10, 5'd26, 32'hF0F0, 5'd27, 32'h0FF0, 5'd28, 32'h25, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'hFFF0) begin failures++; $display("FAIL or got=%h exp=fff0", Alu_result_out); end
    drive(2'b10, 5'd29, 32'h0, 5'd30, 32'h0, 5'd31, 32'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'h0 || Zero_out !== 1'b1)
      begin failures++; $display("FAIL and_zero got res=%h zero=%b exp res=0 zero=1", Alu_result_out, Zero_out); end
    drive(2'b10, 5'd1, 32'd5, 5'd2, 32'd6, 5'd4, 32'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'h0 || Reg_w_out !== 1'b1 || Wr_addr_out !== 5'd4)
      begin failures++; $display("FAIL bad_funct got res=%h rw=%b wr=%0d exp res=0 rw=1 wr=4", Alu_result_out, Reg_w_out, Wr_addr_out); end
    drive(2'b11, 5'd1, 32'd5, 5'd2, 32'd6, 5'd5, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (Alu_result_out !== 32'd11) begin failures++; $display("FAIL op11_add got=%0d exp=11", Alu_result_out); end
  endtask

`ifdef MULT_EN
  task automatic test_mult();
    int n;
    int bad;
    n = 0; bad = 0;
    drive(2'b10, 5'd1, 32'd6, 5'd2, 32'd7, 5'd5, 32'h18, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (Stall_out !== 1'b1) begin failures++; $display("FAIL mult_stall_start got=%b exp=1", Stall_out); end
    while (Stall_out === 1'b1 && n < 100) begin
      tick();
      n++;
      if (Reg_w_out !== 1'b0 || Alu_result_out !== 32'h0 || Wr_addr_out !== 5'd0) bad++;
      if (n == 3) Rs_data_in = 32'd100;
    end
    checks++; if (n !== 33) begin failures++; $display("FAIL mult_stall_len got=%0d exp=33", n); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL mult_bubbles got=%0d non-bubble cycles exp=0", bad); end
    tick();
    checks++; if (Alu_result_out !== 32'd42 || Wr_addr_out !== 5'd5 || Reg_w_out !== 1'b1)
      begin failures++; $display("FAIL mult_result got res=%0d wr=%0d rw=%b exp res=42 wr=5 rw=1", Alu_result_out, Wr_addr_out, Reg_w_out); end
    drive(2'b10, 5'd1, 32'd6, 5'd2, 32'd7, 5'd6, 32'h18, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    drive(2'b10, 5'd1, 32'd3, 5'd2, 32'd4, 5'd0, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    checks++; if (Alu_result_out !== 32'h0 || Reg_w_out !== 1'b0 || Stall_out !== 1'b0)
      begin failures++; $display("FAIL mult_abort got res=%h rw=%b stall=%b exp 0 0 0", Alu_result_out, Reg_w_out, Stall_out); end
    tick();
    checks++; if (Alu_result_out !== 32'd7 || Reg_w_out !== 1'b0)
      begin failures++; $display("FAIL mult_abort_next got res=%0d rw=%b exp res=7 rw=0", Alu_result_out, Reg_w_out); end
  endtask
`else
  task automatic test_mult();
    drive(2'b10, 5'd1, 32'd6, 5'd2, 32'd7, 5'd5, 32'h18, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (Stall_out !== 1'b0) begin failures++; $display("FAIL mult_off_stall got=%b exp=0", Stall_out); end
    tick();
    checks++; if (Alu_result_out !== 32'h0 || Reg_w_out !== 1'b1)
      begin failures++; $display("FAIL mult_off_result got res=%h rw=%b exp res=0 rw=1", Alu_result_out, Reg_w_out); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    #2;
    test_reset();
    test_sub();
    test_forward();
    test_mem();
    test_logic();
    test_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
